// File: rtl/cla16_clu.sv
// 16-bit two-level carry-lookahead adder: four 4-bit CLA slices plus a lookahead
// carry unit, with sum, carry-out and block propagate/generate registered.
module cla16_clu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        in,
    output logic [15:0] S,
    output logic        Cout,
    output logic        Pout,
    output logic        Gout
);

    logic [3:0]  sp;
    logic [3:0]  sg;
    logic        c4, c8, c12, c16;
    logic [15:0] s_c;
    logic        pout_c, gout_c;

    // Slice block {G, P}; independent of carry-in so the CLU can run in parallel.
    function automatic logic [1:0] slice_pg(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p, g;
        logic       gp, pp;
        p  = a ^ b;
        g  = a & b;
        pp = &p;
        gp = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        return {gp, pp};
    endfunction

    // Flat lookahead carries inside a slice; no carry depends on a neighbouring carry.
    function automatic logic [3:0] slice_sum(input logic [3:0] a, input logic [3:0] b,
                                             input logic ci);
        logic [3:0] p, g, c;
        p    = a ^ b;
        g    = a & b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        return p ^ c;
    endfunction

    always_comb begin
        sp = '0;
        sg = '0;
        for (int k = 0; k < 4; k++) begin
            {sg[k], sp[k]} = slice_pg(A[4*k +: 4], B[4*k +: 4]);
        end

        c4  = sg[0] | (sp[0] & in);
        c8  = sg[1] | (sp[1] & sg[0]) | (sp[1] & sp[0] & in);
        c12 = sg[2] | (sp[2] & sg[1]) | (sp[2] & sp[1] & sg[0]) | (sp[2] & sp[1] & sp[0] & in);
        c16 = sg[3] | (sp[3] & sg[2]) | (sp[3] & sp[2] & sg[1]) | (sp[3] & sp[2] & sp[1] & sg[0])
            | (sp[3] & sp[2] & sp[1] & sp[0] & in);

        pout_c = &sp;
        gout_c = sg[3] | (sp[3] & sg[2]) | (sp[3] & sp[2] & sg[1]) | (sp[3] & sp[2] & sp[1] & sg[0]);

        s_c[3:0]   = slice_sum(A[3:0],   B[3:0],   in);
        s_c[7:4]   = slice_sum(A[7:4],   B[7:4],   c4);
        s_c[11:8]  = slice_sum(A[11:8],  B[11:8],  c8);
        s_c[15:12] = slice_sum(A[15:12], B[15:12], c12);
    end

    // Output register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S    <= '0;
            Cout <= 1'b0;
            Pout <= 1'b0;
            Gout <= 1'b0;
        end else begin
            S    <= s_c;
            Cout <= c16;
            Pout <= pout_c;
            Gout <= gout_c;
        end
    end

endmodule

// File: tb/tb_cla16_clu.sv
// Randomized and directed bench for cla16_clu against an arithmetic reference model.
module tb_cla16_clu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] a, b;
    logic        cin;
    logic [15:0] S;
    logic        Cout, Pout, Gout;

    int checks = 0;
    int errors = 0;

    cla16_clu dut (
        .clk  (clk),
        .rst_n(rst_n),
        .A    (a),
        .B    (b),
        .in   (cin),
        .S    (S),
        .Cout (Cout),
        .Pout (Pout),
        .Gout (Gout)
    );

    always #5 clk = ~clk;

    // Reference: {gout, pout, cout, s} from plain integer addition.
    function automatic logic [18:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic ci);
        logic [16:0] sum, sum_nc;
        logic        p;
        sum    = {1'b0, x} + {1'b0, y} + {16'd0, ci};
        sum_nc = {1'b0, x} + {1'b0, y};
        p      = ((x ^ y) == 16'hFFFF);
        return {sum_nc[16], p, sum};
    endfunction

    task automatic test_reset();
        logic [18:0] exp;
        rst_n = 1'b0; a = 16'hFFFF; b = 16'h0001; cin = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({Gout, Pout, Cout, S} !== 19'd0) begin
            errors++;
            $display("FAIL reset_hold: got G=%0b P=%0b C=%0b S=%h expected all zero", Gout, Pout, Cout, S);
        end
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        exp = model(a, b, cin);
        checks++;
        if ({Gout, Pout, Cout, S} !== {1'b1, 1'b0, 1'b1, 16'h0001} || {Gout, Pout, Cout, S} !== exp) begin
            errors++;
            $display("FAIL reset_release: got G=%0b P=%0b C=%0b S=%h expected G=1 P=0 C=1 S=0001", Gout, Pout, Cout, S);
        end
    endtask

    // Directed vectors: {A, B, in, expected G, P, C, S}
    task automatic test_directed();
        logic [15:0] ta [6] = '{16'h99DE, 16'h7914, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h0000};
        logic [15:0] tb [6] = '{16'hB81B, 16'hA82B, 16'h0000, 16'h0000, 16'h8000, 16'h0000};
        logic        tc [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [18:0] te [6] = '{{3'b101, 16'h51FA}, {3'b101, 16'h213F}, {3'b010, 16'hFFFF},
                                {3'b011, 16'h0000}, {3'b101, 16'h0000}, {3'b000, 16'h0001}};
        for (int i = 0; i < 6; i++) begin
            a = ta[i]; b = tb[i]; cin = tc[i];
            @(posedge clk); @(negedge clk);
            checks++;
            if ({Gout, Pout, Cout, S} !== te[i]) begin
                errors++;
                $display("FAIL directed_%0d: got G=%0b P=%0b C=%0b S=%h expected G=%0b P=%0b C=%0b S=%h",
                         i, Gout, Pout, Cout, S, te[i][18], te[i][17], te[i][16], te[i][15:0]);
            end
            checks++;
            if (model(ta[i], tb[i], tc[i]) !== {Gout, Pout, Cout, S}) begin
                errors++;
                $display("FAIL directed_model_%0d: got %h model %h", i, {Gout, Pout, Cout, S},
                         model(ta[i], tb[i], tc[i]));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [18:0] exp;
        logic        cin_prev;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        exp = model(a, b, cin); cin_prev = cin;
        for (int i = 0; i < 1200; i++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if ({Cout, S} !== exp[16:0]) begin
                errors++;
                $display("FAIL b2b_sum_%0d: got %h expected %h", i, {Cout, S}, exp[16:0]);
            end
            checks++;
            if ({Gout, Pout} !== exp[18:17]) begin
                errors++;
                $display("FAIL b2b_pg_%0d: got G=%0b P=%0b expected G=%0b P=%0b", i, Gout, Pout, exp[18], exp[17]);
            end
            checks++;
            if (Cout !== (Gout | (Pout & cin_prev))) begin
                errors++;
                $display("FAIL b2b_carry_rel_%0d: got C=%0b expected %0b", i, Cout, Gout | (Pout & cin_prev));
            end
            // Bias some vectors toward long propagate chains.
            a = 16'($urandom);
            b = ($urandom_range(0, 3) == 0) ? ~a : 16'($urandom);
            cin = 1'($urandom);
            exp = model(a, b, cin); cin_prev = cin;
        end
    endtask

    task automatic test_async_reset();
        logic [18:0] exp;
        a = 16'hFFFF; b = 16'h0000; cin = 1'b0;
        @(posedge clk); #2;
        checks++;
        if ({Pout, S} !== {1'b1, 16'hFFFF}) begin
            errors++;
            $display("FAIL async_pre: got P=%0b S=%h expected P=1 S=ffff", Pout, S);
        end
        rst_n = 1'b0; #1;
        checks++;
        if ({Gout, Pout, Cout, S} !== 19'd0) begin
            errors++;
            $display("FAIL async_clear: got G=%0b P=%0b C=%0b S=%h expected all zero", Gout, Pout, Cout, S);
        end
        @(posedge clk); @(negedge clk);
        checks++;
        if ({Gout, Pout, Cout, S} !== 19'd0) begin
            errors++;
            $display("FAIL async_hold: got G=%0b P=%0b C=%0b S=%h expected all zero", Gout, Pout, Cout, S);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            exp = model(a, b, cin);
            @(posedge clk); @(negedge clk);
            checks++;
            if ({Gout, Pout, Cout, S} !== exp) begin
                errors++;
                $display("FAIL async_resume_%0d: got %h expected %h", i, {Gout, Pout, Cout, S}, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cla16_clu.md
Name: cla16_clu

Overview:
16-bit two-level carry-lookahead adder with registered outputs.
- Level 1: four 4-bit CLA slices.
- Level 2: a 4-bit lookahead carry unit (CLU) that produces the inter-slice carries and the block propagate/generate.
- Pout/Gout allow cascading into a higher-level CLU (e.g. a 64-bit adder).
- The arithmetic core is purely combinational. Results are captured in an output register on the rising clock edge.

Parameters:
- None. Width is fixed at 16 bits: 4 slices × 4 bits.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- A  input  16  addend A, unsigned / two's complement
- B  input  16  addend B
- in  input  1  carry-in to bit 0
- S  output  16  registered sum, (A+B+in) mod 2^16
- Cout  output  1  registered carry-out of bit 15
- Pout  output  1  registered block propagate
- Gout  output  1  registered block generate

Behaviour:
- Bit level, i = 0..15:
  - p_i = A[i] XOR B[i]
  - g_i = A[i] AND B[i]
- Slice k (bits 4k..4k+3):
  - Internal carries use the flat lookahead form, e.g. c1 = g0 | p0·cin and c2 = g1 | p1·g0 | p1·p0·cin. No ripple is allowed.
  - Slice propagate: P_k = p3·p2·p1·p0.
  - Slice generate: G_k = g3 | p3·g2 | p3·p2·g1 | p3·p2·p1·g0.
  - Sum bit: s_i = p_i XOR c_i.
- CLU, from P_0..3, G_0..3 and cin = in:
  - C4 = G0 | P0·in
  - C8 = G1 | P1·G0 | P1·P0·in
  - C12 = G2 | P2·G1 | P2·P1·G0 | P2·P1·P0·in
  - C16 = G3 | P3·G2 | P3·P2·G1 | P3·P2·P1·G0 | P3·P2·P1·P0·in
  - C4, C8 and C12 feed slices 1–3 as their carry-ins.
- Block outputs, before the register:
  - Pout_c = P3·P2·P1·P0, i.e. 1 iff (A XOR B) == 0xFFFF.
  - Gout_c = G3 | P3·G2 | P3·P2·G1 | P3·P2·P1·G0. This is independent of `in`.
  - Cout_c = C16, which must equal Gout_c | (Pout_c·in).
- Register:
  - On every rising clk edge, {S, Cout, Pout, Gout} <= {s, Cout_c, Pout_c, Gout_c}.
  - There is no enable; the register loads every cycle.
  - Latency is 1 cycle: inputs applied before edge N appear on the outputs after edge N.
  - Throughput is one addition per cycle.
- Reset:
  - rst_n low clears S = 0x0000 and Cout = Pout = Gout = 0 immediately, without waiting for a clock edge.
  - Outputs stay cleared while rst_n is low, regardless of clock activity.
  - After rst_n deasserts, the first rising edge loads the result for the current inputs.
  - Reset asserted mid-stream discards the pending result; no state survives reset.
- Invariant: {Cout, S} == A + B + in (17-bit), checked one cycle after the inputs are applied.
- Boundary cases:
  - Full propagate chain with in=1 yields S=0 and Cout=1.
  - A wrap-around carry is never fed back to the input.

Test Plan:
- Reset with rst_n=0 while A=0xFFFF, B=0x0001, in=1 and the clock toggles → S=0x0000, Cout=0, Pout=0, Gout=0. Then release reset → after 1 edge S=0x0001, Cout=1, Pout=0, Gout=1.
- A=0x99DE, B=0xB81B, in=1 → after 1 edge S=0x51FA, Cout=1, Gout=1, Pout=0. Then A=0x7914, B=0xA82B, in=0 → S=0x213F, Cout=1, Gout=1, Pout=0.
- Full propagate chain:
  - A=0xFFFF, B=0x0000, in=0 → S=0xFFFF, Cout=0, Pout=1, Gout=0.
  - Same with in=1 → S=0x0000, Cout=1, Pout=1, Gout=0.
- Generate only: A=0x8000, B=0x8000, in=0 → S=0x0000, Cout=1, Gout=1, Pout=0. Also A=0x0000, B=0x0000, in=1 → S=0x0001, Cout=0, Gout=0, Pout=0.
- Back-to-back random vectors (≥1000) applied every cycle → each cycle {Cout,S} equals the previous cycle's A+B+in, Pout equals the previous cycle's &(A^B), and Cout equals Gout|(Pout&in_prev).
- Assert rst_n low asynchronously between clock edges mid-stream → outputs go to 0 before the next edge and resume correct 1-cycle-latency results after release.
